// File: rtl/sd_init_seq.sv
// SD card initialization sequencer: CMD8, CMD55/ACMD41 polling, CMD2, CMD3, CMD7.
// Define SD_WIDE_BUS_EN to append CMD55/ACMD6, which switches the card to a 4-bit bus.
module sd_init_seq (
  input  logic        iclk,
  input  logic        irst_n,
  input  logic        istart,
  output logic        ocmd_start,
  output logic [5:0]  ocmd_index,
  output logic [31:0] ocmd_arg,
  input  logic [75:0] iresp,
  input  logic        icmd_done,
  output logic [15:0] orca,
  output logic        ohcs,
  output logic        oready,
  output logic        oerror,
  output logic [3:0]  ostate
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_CMD8   = 4'd1;
  localparam logic [3:0] S_CMD55  = 4'd2;
  localparam logic [3:0] S_ACMD41 = 4'd3;
  localparam logic [3:0] S_CMD2   = 4'd4;
  localparam logic [3:0] S_CMD3   = 4'd5;
  localparam logic [3:0] S_CMD7   = 4'd6;
`ifdef SD_WIDE_BUS_EN
  localparam logic [3:0] S_CMD55B = 4'd7;
  localparam logic [3:0] S_ACMD6  = 4'd8;
`endif
  localparam logic [3:0] S_READY  = 4'd9;
  localparam logic [3:0] S_ERROR  = 4'd10;

  // Driver handshake: ocmd_start pulses once with index/arg already stable; the
  // driver answers with a single icmd_done pulse, and iresp is valid in that cycle.
  logic [3:0]  state, state_nxt;
  logic [7:0]  retry;
  logic [9:0]  wd;
  logic [15:0] rca_nxt;
  logic        waiting, done_ok, timeout;
  logic        unused_resp;

  function automatic logic is_cmd(input logic [3:0] s);
    case (s)
      S_CMD8, S_CMD55, S_ACMD41, S_CMD2, S_CMD3, S_CMD7: is_cmd = 1'b1;
`ifdef SD_WIDE_BUS_EN
      S_CMD55B, S_ACMD6: is_cmd = 1'b1;
`endif
      default: is_cmd = 1'b0;
    endcase
  endfunction

  function automatic logic [5:0] cmd_index(input logic [3:0] s);
    case (s)
      S_CMD8:   cmd_index = 6'd8;
      S_CMD55:  cmd_index = 6'd55;
      S_ACMD41: cmd_index = 6'd41;
      S_CMD2:   cmd_index = 6'd2;
      S_CMD3:   cmd_index = 6'd3;
      S_CMD7:   cmd_index = 6'd7;
`ifdef SD_WIDE_BUS_EN
      S_CMD55B: cmd_index = 6'd55;
      S_ACMD6:  cmd_index = 6'd6;
`endif
      default:  cmd_index = 6'd0;
    endcase
  endfunction

  function automatic logic [31:0] cmd_arg(input logic [3:0] s, input logic [15:0] rca);
    case (s)
      S_CMD8:   cmd_arg = 32'h0000_01AA;
      S_ACMD41: cmd_arg = 32'h40FF_8000;
      S_CMD7:   cmd_arg = {rca, 16'h0000};
`ifdef SD_WIDE_BUS_EN
      S_CMD55B: cmd_arg = {rca, 16'h0000};
      S_ACMD6:  cmd_arg = 32'h0000_0002;
`endif
      default:  cmd_arg = 32'h0000_0000;
    endcase
  endfunction

  // The start cycle itself is not part of the wait phase.
  assign waiting = is_cmd(state) && !ocmd_start;
  assign done_ok = waiting && icmd_done;
  assign timeout = waiting && !icmd_done && (wd == 10'd1023);

  assign unused_resp = ^{iresp[75:32], iresp[15:12]};

  always_comb begin
    state_nxt = state;
    rca_nxt   = orca;
    if (timeout) begin
      state_nxt = S_ERROR;
    end else begin
      case (state)
        S_IDLE:   if (istart) state_nxt = S_CMD8;
        S_CMD8:   if (done_ok) state_nxt = (iresp[11:0] == 12'h1AA) ? S_CMD55 : S_ERROR;
        S_CMD55:  if (done_ok) state_nxt = S_ACMD41;
        S_ACMD41: if (done_ok) begin
          if (iresp[31])              state_nxt = S_CMD2;
          else if (retry == 8'd255)   state_nxt = S_ERROR;
          else                        state_nxt = S_CMD55;
        end
        S_CMD2:   if (done_ok) state_nxt = S_CMD3;
        S_CMD3:   if (done_ok) begin
          rca_nxt   = iresp[31:16];
          state_nxt = (iresp[31:16] == 16'h0000) ? S_ERROR : S_CMD7;
        end
`ifdef SD_WIDE_BUS_EN
        S_CMD7:   if (done_ok) state_nxt = S_CMD55B;
        S_CMD55B: if (done_ok) state_nxt = S_ACMD6;
        S_ACMD6:  if (done_ok) state_nxt = S_READY;
`else
        S_CMD7:   if (done_ok) state_nxt = S_READY;
`endif
        default:  state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state      <= S_IDLE;
      ocmd_start <= 1'b0;
      ocmd_index <= 6'd0;
      ocmd_arg   <= 32'h0;
      orca       <= 16'h0;
      ohcs       <= 1'b0;
      retry      <= 8'd0;
      wd         <= 10'd0;
    end else begin
      state      <= state_nxt;
      ocmd_start <= 1'b0;
      // Index/arg are loaded on entry so the driver sees them with the start pulse.
      if (state_nxt != state && is_cmd(state_nxt)) begin
        ocmd_start <= 1'b1;
        ocmd_index <= cmd_index(state_nxt);
        ocmd_arg   <= cmd_arg(state_nxt, rca_nxt);
        wd         <= 10'd0;
      end else if (is_cmd(state)) begin
        wd <= wd + 10'd1;
      end
      if (state == S_IDLE && istart) retry <= 8'd0;
      if (state == S_ACMD41 && done_ok) begin
        if (iresp[31])              ohcs  <= iresp[30];
        else if (retry != 8'd255)   retry <= retry + 8'd1;
      end
      if (state == S_CMD3 && done_ok) orca <= iresp[31:16];
    end
  end

  assign oready = (state == S_READY);
  assign oerror = (state == S_ERROR);
  assign ostate = state;

endmodule

// File: tb/tb_sd_init_seq.sv
// Bench for sd_init_seq: a randomized card/driver responder plus a command-list
// reference model derived from the initialization rules.
module tb_sd_init_seq;

`ifdef SD_WIDE_BUS_EN
  localparam bit WIDE = 1'b1;
`else
  localparam bit WIDE = 1'b0;
`endif

  logic        iclk = 1'b0;
  logic        irst_n;
  logic        istart;
  logic        ocmd_start;
  logic [5:0]  ocmd_index;
  logic [31:0] ocmd_arg;
  logic [75:0] iresp;
  logic        icmd_done;
  logic [15:0] orca;
  logic        ohcs;
  logic        oready;
  logic        oerror;
  logic [3:0]  ostate;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [37:0] exp_q[$];

  sd_init_seq dut (
    .iclk(iclk), .irst_n(irst_n), .istart(istart),
    .ocmd_start(ocmd_start), .ocmd_index(ocmd_index), .ocmd_arg(ocmd_arg),
    .iresp(iresp), .icmd_done(icmd_done),
    .orca(orca), .ohcs(ohcs), .oready(oready), .oerror(oerror), .ostate(ostate)
  );

  // clock / reset
  always #5 iclk = ~iclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge iclk);
    #1;
    cyc++;
  endtask

  task automatic rand_idle_inputs();
    logic [63:0] r64;
    logic [31:0] r32;
    r64 = {$urandom, $urandom};
    r32 = $urandom;
    icmd_done = 1'b0;
    iresp = {r64[43:0], r32};
  endtask

  // hold_mode: 0 normal, 1 CMD2 response withheld, 2 CMD2 response in 1023rd wait cycle
  task automatic run_scenario(input logic [11:0] echo, input int busy_n, input logic hcs,
                              input logic [15:0] rca, input int hold_mode,
                              input bit abort41, input bit spurious);
    logic [37:0] got;
    logic [63:0] r64;
    logic [31:0] r32, rarg;
    logic [5:0]  cur_idx;
    logic [15:0] exp_rca;
    logic        exp_rdy, exp_err, exp_hcs;
    int start_cyc, lat, next_evt, n41, budget, abort_at, attempts;
    bit pending, fin, aborted;

    // reference model: expected command list and final outcome
    exp_q.delete();
    exp_rdy = 1'b0; exp_err = 1'b0; exp_hcs = 1'b0; exp_rca = 16'h0;
    exp_q.push_back({6'd8, 32'h0000_01AA});
    if (echo != 12'h1AA) exp_err = 1'b1;
    else begin
      attempts = (busy_n >= 256) ? 256 : busy_n + 1;
      for (int i = 0; i < attempts; i++) begin
        exp_q.push_back({6'd55, 32'h0});
        exp_q.push_back({6'd41, 32'h40FF_8000});
      end
      if (busy_n >= 256) exp_err = 1'b1;
      else begin
        exp_hcs = hcs;
        exp_q.push_back({6'd2, 32'h0});
        if (hold_mode == 1) exp_err = 1'b1;
        else begin
          exp_q.push_back({6'd3, 32'h0});
          exp_rca = rca;
          if (rca == 16'h0) exp_err = 1'b1;
          else begin
            exp_q.push_back({6'd7, rca, 16'h0});
            if (WIDE) begin
              exp_q.push_back({6'd55, rca, 16'h0});
              exp_q.push_back({6'd6, 32'h2});
            end
            exp_rdy = 1'b1;
          end
        end
      end
    end

    irst_n = 1'b0; istart = 1'b0; icmd_done = 1'b0;
    repeat (3) step();
    check("rst_outs", {ocmd_start, ocmd_index, ocmd_arg, orca, ohcs, oready, oerror}, 64'h0);
    irst_n = 1'b1;

    // IDLE must ignore stray done pulses
    repeat ($urandom_range(2, 6)) begin
      rand_idle_inputs();
      icmd_done = $urandom_range(0, 1);
      step();
      check("idle_quiet", ocmd_start, 1'b0);
    end

    rand_idle_inputs();
    istart = 1'b1;
    next_evt = cyc + 1;
    pending = 0; fin = 0; aborted = 0; n41 = 0; budget = 0; abort_at = 0;
    lat = 0; start_cyc = 0; cur_idx = 6'd0; rarg = 32'h0;
    while (!fin && budget < 20000) begin
      step();
      budget++;
      istart = 1'b0;
      rand_idle_inputs();
      if (ocmd_start) begin
        check("evt_time", cyc, next_evt);
        got = {ocmd_index, ocmd_arg};
        if (exp_q.size() == 0) check("extra_cmd", got, 64'h0);
        else                   check("cmd", got, exp_q.pop_front());
        pending = 1; start_cyc = cyc; cur_idx = ocmd_index;
        lat = $urandom_range(1, 8);
        r32 = $urandom;
        case (ocmd_index)
          6'd8:  rarg = {r32[31:12], echo};
          6'd41: begin
            rarg = (n41 < busy_n) ? 32'h00FF_8000 : (32'h80FF_8000 | ({31'h0, hcs} << 30));
            n41++;
            if (abort41) begin
              lat = 8;
              abort_at = cyc + $urandom_range(1, 4);
            end
          end
          6'd3:  rarg = {rca, r32[15:0]};
          default: rarg = r32;
        endcase
        if (ocmd_index == 6'd2 && hold_mode == 1) begin
          lat = 1 << 30;
          next_evt = cyc + 1024;
        end
        if (ocmd_index == 6'd2 && hold_mode == 2) lat = 1023;
        if (spurious) begin
          r64 = {$urandom, $urandom};
          icmd_done = 1'b1;
          iresp = {r64[36:0], 1'b0, cur_idx, ~rarg};
        end
      end else if (abort41 && abort_at != 0 && cyc == abort_at) begin
        irst_n = 1'b0;
        #1;
        check("rst_async", {ocmd_start, ocmd_index, ocmd_arg, orca, ohcs, oready, oerror}, 64'h0);
        aborted = 1; fin = 1;
      end else if (pending && cyc == start_cyc + lat) begin
        r64 = {$urandom, $urandom};
        icmd_done = 1'b1;
        iresp = {r64[36:0], 1'b0, cur_idx, rarg};
        pending = 0;
        next_evt = cyc + 1;
      end
      if (!aborted && (oready || oerror)) begin
        check("evt_time", cyc, next_evt);
        fin = 1;
      end
    end
    check("finished", fin, 1'b1);

    if (aborted) begin
      repeat (2) step();
    end else begin
      check("oready", oready, exp_rdy);
      check("oerror", oerror, exp_err);
      check("orca", orca, exp_rca);
      check("ohcs", ohcs, exp_hcs);
      check("cmds_left", exp_q.size(), 0);
      // terminal states ignore istart and stray done pulses
      repeat (20) begin
        rand_idle_inputs();
        istart    = $urandom_range(0, 1);
        icmd_done = $urandom_range(0, 1);
        step();
        check("term_quiet", {ocmd_start, oready, oerror}, {1'b0, exp_rdy, exp_err});
      end
      istart = 1'b0;
      icmd_done = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] r;
    logic [11:0] echo;
    irst_n = 1'b0; istart = 1'b0; icmd_done = 1'b0; iresp = '0;

    run_scenario(12'h1AA, 0,   1'b1, 16'h1234, 0, 0, 0);
    r = $urandom;
    run_scenario(12'h1AA, 3,   1'b0, r[15:0] | 16'h0001, 0, 0, 0);
    run_scenario(12'h1AA, 256, 1'b1, 16'h55AA, 0, 0, 0);
    run_scenario(12'h2AA, 0,   1'b1, 16'h1234, 0, 0, 0);
    run_scenario(12'h1AA, 0,   1'b1, 16'hBEEF, 1, 0, 0);
    run_scenario(12'h1AA, 1,   1'b0, 16'hBEEF, 2, 0, 0);
    run_scenario(12'h1AA, 0,   1'b1, 16'h0000, 0, 0, 0);
    run_scenario(12'h1AA, 255, 1'b1, 16'hFFFF, 0, 0, 0);
    run_scenario(12'h1AA, 5,   1'b1, 16'h1234, 0, 1, 0);
    run_scenario(12'h1AA, 2,   1'b1, 16'h4321, 0, 0, 0);

    for (int k = 0; k < 6; k++) begin
      r = $urandom;
      echo = ($urandom_range(0, 3) == 0) ? r[27:16] : 12'h1AA;
      run_scenario(echo, $urandom_range(0, 4), r[31], r[15:0], 0, 0, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sd_init_seq.md
SD_INIT_SEQ -- requirements
Module: sd_init_seq

Interface
REQ-001 iclk  input  1  SD clock; the same clock that drives the CMD line driver.
REQ-002 irst_n  input  1  reset, asynchronous, active-low.
REQ-003 istart  input  1  single-cycle pulse that starts the initialization sequence; sampled only in IDLE.
REQ-004 ocmd_start  output  1  single-cycle command start pulse to the CMD line driver.
REQ-005 ocmd_index  output  6  command index to the CMD line driver; held stable while a command is outstanding.
REQ-006 ocmd_arg  output  32  command argument to the CMD line driver; held stable while a command is outstanding.
REQ-007 iresp  input  76  received response from the CMD line driver; for 48-bit responses {tx, index[5:0], arg[31:0]} occupies iresp[38:0].
REQ-008 icmd_done  input  1  single-cycle pulse from the CMD line driver: command and response completed with good CRC.
REQ-009 orca  output  16  card relative address captured from the CMD3 response.
REQ-010 ohcs  output  1  card capacity status, taken from OCR bit 30 of the final ACMD41 response.
REQ-011 oready  output  1  high while in READY.
REQ-012 oerror  output  1  high while in ERROR.

Function
REQ-013 FSM states: IDLE, CMD8, CMD55, ACMD41, CMD2, CMD3, CMD7, CMD55B, ACMD6, READY, ERROR.
REQ-014 IDLE to CMD8 on istart; CMD0 is never issued, and the card is required to be in idle state after power-up.
REQ-015 Each command state asserts ocmd_start for exactly its first cycle, then waits for icmd_done; on icmd_done it evaluates iresp in the same cycle and transitions on the next edge.
REQ-016 CMD8: arg 32'h000001AA; iresp[11:0] not equal to 12'h1AA leads to ERROR, otherwise CMD55.
REQ-017 CMD55: arg 32'h0, then ACMD41.
REQ-018 ACMD41: index 41, arg 32'h40FF8000; iresp[31]=1 latches ohcs=iresp[30] and goes to CMD2; iresp[31]=0 increments an 8-bit retry counter and returns to CMD55.
REQ-019 ACMD41 retry limit: when iresp[31]=0 and the retry counter already equals 255, go to ERROR (256 attempts maximum).
REQ-020 CMD2: arg 32'h0; the response content is ignored; then CMD3.
REQ-021 CMD3: arg 32'h0; latch orca=iresp[31:16]; an RCA of 16'h0000 leads to ERROR, otherwise CMD7.
REQ-022 CMD7: arg {orca,16'h0}; then CMD55B (when wide bus is enabled) or READY.
REQ-023 CMD55B: index 55, arg {orca,16'h0}; then ACMD6.
REQ-024 ACMD6: index 6, arg 32'h00000002; then READY.
REQ-025 Watchdog: a 10-bit counter clears at every ocmd_start and increments while waiting; reaching 1023 without icmd_done goes to ERROR.
REQ-026 If icmd_done and the watchdog limit coincide, icmd_done takes priority.
REQ-027 icmd_done received outside a wait phase is ignored.
REQ-028 READY and ERROR are terminal; istart is ignored in both; only reset exits them.
REQ-029 ocmd_index and ocmd_arg are registered and updated on entry to each command state, so they are valid in the ocmd_start cycle.

Reset
REQ-030 Asynchronous assertion of irst_n low forces IDLE at any point, including mid-command.
REQ-031 Reset values: ocmd_start=0, ocmd_index=0, ocmd_arg=0, orca=0, ohcs=0, oready=0, oerror=0, retry counter=0, watchdog=0.

Configuration
REQ-032 Macro SD_WIDE_BUS_EN, when defined: CMD7 goes to CMD55B, then ACMD6, then READY (4-bit bus).
REQ-033 When SD_WIDE_BUS_EN is undefined: CMD7 goes to READY, and the CMD55B and ACMD6 states and their logic are not compiled in.

Verification
REQ-034 Nominal: CMD8 response arg 0x1AA, ACMD41 returns 0xC0FF8000 on the first try, CMD3 returns 0x12340000 -> indices 8,55,41,2,3,7(,55,6) issued in order; orca=0x1234; ohcs=1; oready=1.
REQ-035 ACMD41 reports busy three times, then 0x80FF8000 -> four CMD55/ACMD41 pairs issued; ohcs=0; oready=1.
REQ-036 ACMD41 always returns 0x00FF8000 -> exactly 256 ACMD41 issued, then oerror=1 and no further ocmd_start.
REQ-037 CMD8 response arg 0x000002AA -> oerror=1 one cycle after icmd_done; no CMD55 issued.
REQ-038 icmd_done withheld after CMD2 -> oerror=1 after 1023 wait cycles; icmd_done arriving in the 1023rd cycle -> CMD3 issued instead.
REQ-039 irst_n pulsed low during ACMD41 wait -> all outputs return to reset values immediately; a new istart restarts from CMD8 with retry counter 0.
